// File: rtl/alu_mult_seq.sv
// alu_mult_seq: radix-2 Booth 32x32 signed multiplier that borrows the external ALU for its add/subtract.
// Define ALU_MULT_ZERO_SKIP_EN to finish multiplies with a zero operand immediately.
module alu_mult_seq #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        result_ready,
    output logic [31:0] result,
    output logic        result_ovf,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q;
    logic [31:0] m_q, a_q, q_q, result_q;
    logic        q1_q, ovf_q, busy_q, ready_q;
    logic [5:0]  count_q;
    logic        run, add_m, s, zero_op;
    logic [31:0] a_d, q_d;
    assign run          = state_q == RUN;
    assign add_m        = q_q[0] ^ q1_q;
    assign alu_opcode   = {4'd0, run & q_q[0] & ~q1_q};
    assign alu_opA      = run ? a_q : '0;
    assign alu_opB      = run && add_m ? m_q : '0;
    assign alu_shamt    = '0;
    assign busy         = busy_q;
    assign result_ready = ready_q;
    assign result       = result_q;
    assign result_ovf   = ovf_q;
    // Overflow flips the ALU sign bit back to the true 33-bit sign, which covers M = 0x80000000.
    assign s   = alu_result[31] ^ alu_overflow;
    assign a_d = {s, alu_result[31:1]};
    assign q_d = {alu_result[0], q_q[31:1]};
`ifdef ALU_MULT_ZERO_SKIP_EN
    assign zero_op = multiplicand == '0 || multiplier == '0;
`else
    assign zero_op = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else if (run) begin
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q_q[0];
            count_q <= count_q + 6'd1;
            if (count_q == 6'(ITER - 1)) begin
                result_q <= q_d;
                ovf_q    <= a_d != {32{q_d[31]}};
                state_q  <= DONE;
                busy_q   <= 1'b0;
                ready_q  <= 1'b1;
            end
        end else begin
            ready_q <= 1'b0;
            state_q <= IDLE;
            if (start) begin
                m_q     <= multiplicand;
                q_q     <= multiplier;
                a_q     <= '0;
                q1_q    <= 1'b0;
                count_q <= '0;
                if (zero_op) begin
                    state_q  <= DONE;
                    ready_q  <= 1'b1;
                    result_q <= '0;
                    ovf_q    <= 1'b0;
                end else begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: random and directed multiplies checked every cycle against a product-level model.
module tb_alu_mult_seq;
    logic        clock, reset, start;
    logic [31:0] multiplicand, multiplier;
    logic        busy, result_ready, result_ovf, alu_overflow;
    logic [31:0] result, alu_opA, alu_opB, alu_result;
    logic [4:0]  alu_opcode, alu_shamt;
    int          n_cmp = 0, n_fail = 0;
    bit          chk = 0;
`ifdef ALU_MULT_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif
    alu_mult_seq dut (
        .clock(clock), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .result_ready(result_ready), .result(result), .result_ovf(result_ovf),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_overflow(alu_overflow)
    );
    // The processor's ALU: add or subtract with signed overflow
    assign alu_result   = alu_opcode == 5'd1 ? alu_opA - alu_opB : alu_opA + alu_opB;
    assign alu_overflow = alu_opcode == 5'd1
        ? (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31])
        : (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
    initial clock = 0;
    always #5 clock = ~clock;
    function automatic logic [32:0] ref_mul(logic [31:0] a, logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return {p > 64'sd2147483647 || p < -64'sd2147483648, p[31:0]};
    endfunction
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    int          run_left = 0;
    logic        exp_ready = 0, exp_ovf = 0, pend_ovf = 0;
    logic [31:0] exp_res = 0, pend_res = 0;
    always @(posedge clock) begin
        if (reset) begin
            run_left  <= 0;
            exp_ready <= 0;
            exp_res   <= 0;
            exp_ovf   <= 0;
        end else if (run_left == 0) begin
            exp_ready <= 0;
            if (start) begin
                if (ZS && (multiplicand == 0 || multiplier == 0)) begin
                    exp_ready <= 1;
                    exp_res   <= 0;
                    exp_ovf   <= 0;
                end else begin
                    run_left <= 32;
                    {pend_ovf, pend_res} <= ref_mul(multiplicand, multiplier);
                end
            end
        end else begin
            run_left <= run_left - 1;
            if (run_left == 1) begin
                exp_ready <= 1;
                exp_res   <= pend_res;
                exp_ovf   <= pend_ovf;
            end
        end
    end
    always @(negedge clock) begin
        if (chk) begin
            check("busy", 64'(busy), 64'(run_left != 0));
            check("result_ready", 64'(result_ready), 64'(exp_ready));
            check("result", 64'(result), 64'(exp_res));
            check("result_ovf", 64'(result_ovf), 64'(exp_ovf));
            if (run_left == 0) check("alu_idle", 64'({alu_opcode, alu_opA | alu_opB}), 64'(0));
        end
    end
    task automatic run_mul(logic [31:0] a, logic [31:0] b, logic [32:0] lit, bit use_lit, bit poke);
        int lat;
        @(posedge clock); #1;
        multiplicand = a;
        multiplier   = b;
        start        = 1;
        @(posedge clock); #1;
        start        = 0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat = 0;
        while (!result_ready && lat < 100) begin
            start = poke && lat == 5;
            @(posedge clock); #1;
            lat++;
        end
        start = 0;
        check("latency", 64'(lat), (ZS && (a == 0 || b == 0)) ? 64'd0 : 64'd32);
        if (use_lit) check("literal_product", 64'({result_ovf, result}), 64'(lit));
    endtask
    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 511)) - 32'd256;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int  lat;
        bit  seen;
        reset = 1;
        start = 1;
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        @(posedge clock); #1;
        chk = 1;
        @(posedge clock); #1;
        start = 0;
        reset = 0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(result_ready), 64'd0);
        check("reset_result", 64'({result_ovf, result}), 64'd0);
        run_mul(32'h00000007, 32'hFFFFFFFD, {1'b0, 32'hFFFFFFEB}, 1, 0);
        run_mul(32'h80000000, 32'hFFFFFFFF, {1'b1, 32'h80000000}, 1, 1);
        run_mul(32'h80000000, 32'h00000001, {1'b0, 32'h80000000}, 1, 0);
        run_mul(32'h00010000, 32'h00010000, {1'b1, 32'h00000000}, 1, 1);
        run_mul(32'h0000FFFF, 32'h0000FFFF, {1'b1, 32'hFFFE0001}, 1, 0);
        // Abort at iteration 10
        @(posedge clock); #1;
        multiplicand = 32'd3;
        multiplier   = 32'd4;
        start        = 1;
        @(posedge clock); #1;
        start = 0;
        repeat (9) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;
        reset = 0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'({result_ovf, result}), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            seen |= result_ready;
        end
        check("abort_no_ready", 64'(seen), 64'd0);
        // Back-to-back with start held through DONE
        multiplicand = 32'h00000007;
        multiplier   = 32'hFFFFFFFD;
        start        = 1;
        @(posedge clock); #1;
        multiplicand = 32'hFFFFFFFB;
        multiplier   = 32'hFFFFFFFB;
        lat = 0;
        while (!result_ready && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b_first_latency", 64'(lat), 64'd32);
        check("b2b_first", 64'({result_ovf, result}), {31'd0, 1'b0, 32'hFFFFFFEB});
        lat = 0;
        do begin
            @(posedge clock); #1;
            start = 0;
            lat++;
        end while (!result_ready && lat < 100);
        check("b2b_spacing", 64'(lat), 64'd33);
        check("b2b_second", 64'({result_ovf, result}), 64'h19);
        run_mul(32'h00000000, 32'h12345678, 33'd0, 1, 0);
        for (int i = 0; i < 40; i++)
            run_mul(rnd_op(), rnd_op(), 33'd0, 0, $urandom_range(0, 3) == 0);
        repeat (3) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Sequential signed 32×32 multiplier controller that time-shares the combinational ALU's add/subtract path using radix-2 Booth iteration, one iteration per clock. It sits beside the processor's ALU. While running, it owns the ALU operand and opcode inputs, and the execute stage's mux selects this block's ALU drive whenever `busy` is high. It returns the low 32 bits of the product plus an overflow flag for the processor's multiply-exception path.

## Interface
Parameters:
- `ITER`, default 32: number of Booth iterations, equal to the operand width. Only 32 is supported.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply. Sampled only in IDLE or DONE.
- `multiplicand` in 32: signed operand M, latched on an accepted `start`.
- `multiplier` in 32: signed operand Q, latched on an accepted `start`.
- `busy` out 1: high while in RUN.
- `result_ready` out 1: one-cycle pulse in DONE.
- `result` out 32: low 32 bits of M×Q. Held until the next accepted `start`.
- `result_ovf` out 1: product does not fit in signed 32 bits. Held with `result`.
- `alu_opA` out 32: drive for the ALU's `data_operandA`.
- `alu_opB` out 32: drive for the ALU's `data_operandB`.
- `alu_opcode` out 5: ALU opcode. `00000` is add, `00001` is subtract.
- `alu_shamt` out 5: constant 0.
- `alu_result` in 32: the ALU's `data_result`.
- `alu_overflow` in 1: the ALU's `overflow`.

## Operation
- Registers:
  - `M` (32), `A` (32, partial high product), `Q` (32), `q_1` (1), `count` (6), state.
  - State encoding: IDLE, RUN, DONE.
- Accepted `start` (state is IDLE or DONE):
  - M ← `multiplicand`, Q ← `multiplier`, A ← 0, `q_1` ← 0, `count` ← 0, state → RUN.
  - `result` and `result_ovf` are left unchanged until the final iteration completes.
- `start` in RUN is ignored. There is no queueing.
- ALU drive in RUN, selected by {Q[0], `q_1`}:
  - `10`: opcode `00001`, opA=A, opB=M (A−M).
  - `01`: opcode `00000`, opA=A, opB=M (A+M).
  - `00` or `11`: opcode `00000`, opA=A, opB=0.
- ALU drive in IDLE and DONE: opcode `00000`, opA=0, opB=0.
- Per RUN edge:
  - s = `alu_result[31]` XOR `alu_overflow`. This is the true sign of the 33-bit sum.
  - {A, Q, `q_1`} ← {s, `alu_result`, Q}. This is a 65-bit arithmetic shift right by 1.
  - `count` ← `count`+1.
- When `count` reaches 31 (the 32nd iteration), in addition to the iteration:
  - `result` ← shifted Q.
  - `result_ovf` ← (shifted A ≠ {32{shifted Q[31]}}).
  - State → DONE.
- DONE lasts one cycle, then goes to IDLE unless `start` is high.
- All arithmetic is two's complement. M = 0x80000000 is handled correctly through the s correction.

## Timing
- Reset (when `reset` is high at an edge):
  - State → IDLE.
  - `busy`=0, `result_ready`=0, `result`=0, `result_ovf`=0.
  - All internal registers cleared.
  - Reset overrides `start` in the same cycle.
  - Reset mid-RUN aborts the operation with no `result_ready`.
- `start` accepted at edge E0:
  - `busy`=1 for the 32 cycles following E0.
  - Iterations occur at edges E1..E32.
  - In the cycle after E32: `result_ready`=1, `busy`=0, and `result` is valid.
  - Latency is 33 edges from accepted `start` to `result_ready`.
- `start` high in DONE: re-enters RUN at the next edge. `result_ready` still pulses that cycle. Throughput is one multiply per 33 cycles.
- `alu_*` outputs are combinational from registered state only. The ALU path (`alu_result` → A) is a single-cycle combinational loop through the external ALU.

## Configuration
- `ALU_MULT_ZERO_SKIP_EN`
  - Defined: an accepted `start` where `multiplicand`==0 or `multiplier`==0 goes directly to DONE at E0, with `result`=0 and `result_ovf`=0. `result_ready` rises in the cycle after E0 and `busy` never rises.
  - Undefined: every multiply takes the full 33-edge latency.

## Test plan
- Basic signed product: 7 × (−3) (0x00000007, 0xFFFFFFFD) → after 33 edges, `result`=0xFFFFFFEB, `result_ovf`=0. `busy` is high for exactly 32 cycles and `result_ready` pulses once.
- Most-negative multiplicand: 0x80000000 × 0xFFFFFFFF → `result`=0x80000000, `result_ovf`=1.
  - Also 0x80000000 × 1 → 0x80000000 with `result_ovf`=0.
- Positive overflow: 0x00010000 × 0x00010000 → `result`=0x00000000, `result_ovf`=1.
  - Also 0x0000FFFF × 0x0000FFFF → 0xFFFE0001 with `result_ovf`=1.
- Reset and ignored start:
  - Assert `reset` at iteration 10 → next cycle shows IDLE, `busy`=0, `result`=0, with no `result_ready` pulse.
  - `start` pulsed during RUN does not alter operands or the result.
- Back-to-back: `start` held high through DONE with new operands (−5 × −5) → second `result_ready` exactly 33 edges after the first, with `result`=0x00000019.
- Zero operand: 0 × 0x12345678
  - With `ALU_MULT_ZERO_SKIP_EN`: `result_ready` in the cycle after E0, `result`=0.
  - Without it: `result_ready` 33 edges after E0, `result`=0.
